// File: rtl/tick_gen_multi.sv
// tick_gen_multi: NCH independent programmable tick dividers with glitch-free period
// update, per-channel gating, global resync and a registered selectable tick output.
module tick_gen_multi #(
  parameter int WIDTH = 24,
  parameter int NCH = 3,
  parameter int PULSE_W = 3,
  parameter logic [WIDTH-1:0] DEF_PERIOD = WIDTH'(1000000),
  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [NCH-1:0]   en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CHW-1:0]   wr_ch,
  input  logic [WIDTH-1:0] wr_period,
  input  logic [CHW-1:0]   sel,
  output logic [NCH-1:0]   tick,
  output logic             clk_out
);
  localparam int SELN = 2 ** CHW;
  logic [SELN-1:0] w_tick_pad;
  logic            r_clk_out;
  // zero padding makes any sel beyond the last channel read as 0
  assign w_tick_pad = SELN'(tick);
  assign clk_out = r_clk_out;
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) r_clk_out <= 1'b0;
    else r_clk_out <= w_tick_pad[sel];
  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [WIDTH-1:0] r_cnt, r_period, r_shadow;
    logic             r_pend, r_tick, w_wr, w_load;
    assign w_wr = wr_en && (int'(wr_ch) == i);
    // gating, sync and wrap all restart the count and commit a pending period
    assign w_load = !en[i] || sync || (r_cnt == r_period);
    assign tick[i] = r_tick;
    always_ff @(posedge clk_in or negedge rst_n)
      if (!rst_n) begin
        r_cnt    <= '0;
        r_period <= DEF_PERIOD;
        r_shadow <= DEF_PERIOD;
        r_pend   <= 1'b0;
        r_tick   <= 1'b0;
      end else begin
        r_cnt  <= w_load ? '0 : r_cnt + 1'b1;
        r_tick <= en[i] && (r_cnt < WIDTH'(PULSE_W));
        if (w_load && r_pend) r_period <= r_shadow;
        if (w_wr) r_shadow <= wr_period;
        r_pend <= w_wr || (r_pend && !w_load);
      end
  end
endmodule

// File: tb/tb_tick_gen_multi.sv
// tb_tick_gen_multi: directed stimulus with a cycle-level reference model plus literal pins.
module tb_tick_gen_multi;
  localparam int PW = 3;
  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  en = 3'b001;
  logic        sync = 1'b0;
  logic        wr_en = 1'b0;
  logic [1:0]  wr_ch = 2'd0;
  logic [23:0] wr_period = 24'd0;
  logic [1:0]  sel = 2'd0;
  logic [2:0]  tick;
  logic        clk_out;
  int total = 0, bad = 0;

  tick_gen_multi #(.WIDTH(24), .NCH(3), .PULSE_W(3), .DEF_PERIOD(24'd9)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .en(en), .sync(sync), .wr_en(wr_en), .wr_ch(wr_ch),
    .wr_period(wr_period), .sel(sel), .tick(tick), .clk_out(clk_out));

  always #5 clk_in = ~clk_in;

  // reference model: phase = cycles since the channel last restarted, len = period length
  int ph[3] = '{0, 0, 0};
  int len[3] = '{10, 10, 10};
  int nxt[3] = '{10, 10, 10};
  bit pend[3] = '{0, 0, 0};
  bit [2:0] mt = 3'b000;
  bit mclk = 1'b0;

  always @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        ph[i] = 0; len[i] = 10; nxt[i] = 10; pend[i] = 0;
      end
      mt = 3'b000;
      mclk = 1'b0;
    end else begin
      mclk = (sel < 2'd3) ? mt[sel] : 1'b0;
      for (int i = 0; i < 3; i++) begin
        bit restart;
        mt[i] = en[i] && (ph[i] < PW);
        restart = !en[i] || sync || (ph[i] + 1 == len[i]);
        if (restart && pend[i]) begin
          len[i] = nxt[i];
          pend[i] = 0;
        end
        ph[i] = restart ? 0 : ph[i] + 1;
        if (wr_en && wr_ch == 2'(i)) begin
          nxt[i] = int'(wr_period) + 1;
          pend[i] = 1;
        end
      end
    end

  always @(negedge clk_in)
    if (rst_n === 1'b1) begin
      total++;
      if (tick !== mt) begin
        bad++;
        $display("FAIL model_tick t=%0t got=%b exp=%b", $time, tick, mt);
      end
      total++;
      if (clk_out !== mclk) begin
        bad++;
        $display("FAIL model_clk_out t=%0t got=%b exp=%b", $time, clk_out, mclk);
      end
    end

  task automatic step();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", nm, $time, got, exp);
    end
  endtask

  initial begin
    logic [11:0] v12;
    logic [15:0] v16;
    logic acc;
    int n;
    repeat (3) @(negedge clk_in);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_clk_out", 32'(clk_out), 0);
    rst_n = 1'b1;
    // 1: default period 9 -> 3 high, 7 low
    for (int k = 0; k < 12; k++) begin
      step();
      v12[k] = tick[0];
    end
    chk("t1_ch0_pattern", 32'(v12), 32'hC07);
    chk("t1_ch21_idle", 32'(tick[2:1]), 0);
    // 2: write period 4 while cnt=6
    repeat (4) step();
    wr_en = 1'b1; wr_ch = 2'd0; wr_period = 24'd4;
    for (int k = 0; k < 16; k++) begin
      step();
      wr_en = 1'b0;
      v16[k] = tick[0];
    end
    chk("t2_switch_pattern", 32'(v16), 32'hCE70);
    // 3: period 0 on a gated channel, then an out-of-range write
    wr_en = 1'b1; wr_ch = 2'd1; wr_period = 24'd0;
    step();
    wr_en = 1'b0;
    step();
    en[1] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t3_ch1_const", 32'(tick[1]), 1);
    end
    wr_en = 1'b1; wr_ch = 2'd3; wr_period = 24'd7;
    step();
    wr_en = 1'b0;
    repeat (5) step();
    chk("t3_bad_ch_ignored", 32'(tick[1]), 1);
    en[1] = 1'b0;
    // 4: sync at ch0 cnt=5
    wr_en = 1'b1; wr_ch = 2'd0; wr_period = 24'd9;
    step();
    wr_en = 1'b0;
    en[2] = 1'b1;
    repeat (3) step();
    n = 0;
    while (ph[0] != 5 && n < 40) begin
      step();
      n++;
    end
    chk("t4_reach_cnt5", 32'(n < 40), 1);
    sync = 1'b1;
    step();
    sync = 1'b0;
    chk("t4_sync_edge_ch0", 32'(tick[0]), 0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t4_aligned_high", 32'({tick[2], tick[0]}), 32'h3);
    end
    step();
    chk("t4_aligned_low", 32'(tick), 0);
    // 5: clk_out routing
    sel = 2'd2;
    repeat (12) step();
    sel = 2'd3;
    step();
    acc = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      acc |= clk_out;
    end
    chk("t5_sel3_zero", 32'(acc), 0);
    // 6: reset during a pulse discards programmed periods
    wr_en = 1'b1; wr_ch = 2'd2; wr_period = 24'd2;
    step();
    wr_en = 1'b0;
    repeat (12) step();
    sel = 2'd0;
    step();
    n = 0;
    while (!(mt[0] && mclk) && n < 40) begin
      step();
      n++;
    end
    chk("t6_in_pulse", 32'({tick[0], clk_out}), 32'h3);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_tick", 32'(tick), 0);
    chk("t6_async_clk_out", 32'(clk_out), 0);
    en = 3'b101;
    @(negedge clk_in);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      v12[k] = tick[2];
    end
    chk("t6_ch2_default_period", 32'(v12), 32'hC07);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
